// File: rtl/txuart_fifo.sv
// Buffered 8N1 UART transmitter: 16-entry byte FIFO feeding an LSB-first serialiser.
// Define TXUART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | line high, waiting for the FIFO to become non-empty
// S_START  | driving the start bit (low) for one bit period
// S_DATA   | driving shift[0]; shifts right at the end of each bit period
// S_PARITY | driving XOR of the data byte (TXUART_PARITY_EN builds only)
// S_STOP   | driving the stop bit; pops the next byte on its last cycle
module txuart_fifo #(
    parameter int CLKS_PER_BIT    = 104,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_busy,
    output logic       o_idle,
    output logic       TX
);

    localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
    localparam int BAUD_W = ($clog2(CLKS_PER_BIT) > 8) ? $clog2(CLKS_PER_BIT) : 8;
    localparam logic [BAUD_W-1:0]        BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state, state_nxt;

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count;
    logic [BAUD_W-1:0]          baud_cnt;
    logic [2:0]                 bit_idx;
    logic [7:0]                 shift;
    logic                       baud_last;
    logic                       fifo_empty;
    logic                       push;
    logic                       pop;
    logic                       tx_nxt;
`ifdef TXUART_PARITY_EN
    logic                       parity;
`endif

    assign fifo_empty = (count == '0);
    assign o_busy     = (count == COUNT_FULL);
    assign push       = i_valid && !o_busy;
    assign baud_last  = (baud_cnt == BAUD_LAST);
    // Popping on the last stop-bit cycle lets the next start bit follow with no gap.
    assign pop        = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && baud_last));

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) state_nxt = S_START;
            end
            S_START: begin
                if (baud_last) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (baud_last && (bit_idx == 3'd7)) begin
`ifdef TXUART_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
`ifdef TXUART_PARITY_EN
            S_PARITY: begin
                if (baud_last) state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                if (baud_last) state_nxt = fifo_empty ? S_IDLE : S_START;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
`ifdef TXUART_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            if (state == S_IDLE) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
            end
            if (pop) begin
                shift   <= mem[rd_ptr];
                bit_idx <= '0;
`ifdef TXUART_PARITY_EN
                parity  <= ^mem[rd_ptr];
`endif
            end else if ((state == S_DATA) && baud_last) begin
                shift   <= {1'b0, shift[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    always_comb begin
        tx_nxt = 1'b1;
        case (state)
            S_START: tx_nxt = 1'b0;
            S_DATA:  tx_nxt = shift[0];
`ifdef TXUART_PARITY_EN
            S_PARITY: tx_nxt = parity;
`endif
            default: tx_nxt = 1'b1;
        endcase
    end

    // Line and idle flag are registered so the pin never glitches on state decode.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            TX     <= 1'b1;
            o_idle <= 1'b1;
        end else begin
            TX     <= tx_nxt;
            o_idle <= fifo_empty && (state == S_IDLE);
        end
    end

endmodule
